// File: rtl/mesh_link_channel.sv
// One-direction mesh link: done-handshaked push from upstream tile into a FIFO, first-word fall-through valid/ready pop to downstream.
// Word visible one cycle after accept; sender is held (no done) while full, at most one accept per two cycles.
module mesh_link_channel #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_send_data,
  input  logic             in_send_ready,
  output logic             in_send_done,
  output logic [WIDTH-1:0] out_recv_data,
  output logic             out_recv_valid,
  input  logic             out_recv_ready,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             accept;
  logic             pop;

  // Full is deliberately not pop-aware; a blocked sender waits for count to drop first.
  assign full           = (count == CW'(DEPTH));
  assign accept         = in_send_ready && !full && !in_send_done;
  assign out_recv_valid = (count != '0);
  assign pop            = out_recv_valid && out_recv_ready;
  assign out_recv_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      in_send_done <= 1'b0;
    end else begin
      in_send_done <= accept;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem[wr_ptr] <= in_send_data;
  end

endmodule

// File: tb/tb_mesh_link_channel.sv
// Bench for mesh_link_channel: directed vector table, hand sequences for wrap and mid-stream reset, then random traffic against a queue model.
module tb_mesh_link_channel;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_send_data = '0;
  logic             in_send_ready = 1'b0;
  logic             in_send_done;
  logic [WIDTH-1:0] out_recv_data;
  logic             out_recv_valid;
  logic             out_recv_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             full;

  int checks = 0;
  int errors = 0;

  mesh_link_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_send_data   (in_send_data),
    .in_send_ready  (in_send_ready),
    .in_send_done   (in_send_done),
    .out_recv_data  (out_recv_data),
    .out_recv_valid (out_recv_valid),
    .out_recv_ready (out_recv_ready),
    .count          (count),
    .full           (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        sr;
    logic [31:0] sd;
    logic        rr;
    logic        dn;
    logic        vl;
    logic [31:0] dt;
    logic [2:0]  cn;
    logic        fl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic sr, logic [31:0] sd, logic rr,
                              logic dn, logic vl, logic [31:0] dt, int cn, logic fl);
    vecs.push_back('{r, sr, sd, rr, dn, vl, dt, 3'(cn), fl});
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic        done_m;
  logic        acc_m, pop_m;
  int          n, got, cyc;

  initial begin
    // Reset, idle, single word, fill-to-full, simultaneous push/pop.
    for (int i = 0; i < 2; i++)  add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(0, 1, k,     0, 1, 1, 1, k, k == 4);
      add(0, 1, k + 1, 0, 0, 1, 1, k, k == 4);
    end
    for (int i = 0; i < 3; i++) add(0, 1, 5, 0, 0, 1, 1, 4, 1);
    add(0, 1, 5, 1, 0, 1, 2, 3, 0);
    add(0, 1, 5, 0, 1, 1, 2, 4, 1);
    add(0, 0, 0, 1, 0, 1, 3, 3, 0);
    add(0, 0, 0, 1, 0, 1, 4, 2, 0);
    add(0, 0, 0, 1, 0, 1, 5, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 32'h21, 0, 1, 1, 32'h21, 1, 0);
    add(0, 1, 32'h22, 0, 0, 1, 32'h21, 1, 0);
    add(0, 1, 32'h22, 0, 1, 1, 32'h21, 2, 0);
    add(0, 0, 0,      0, 0, 1, 32'h21, 2, 0);
    add(0, 1, 32'h23, 1, 1, 1, 32'h22, 2, 0);
    add(0, 0, 0,      1, 0, 1, 32'h23, 1, 0);
    add(0, 0, 0,      1, 0, 0, 0,      0, 0);

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].r; in_send_ready = vecs[i].sr;
      in_send_data = vecs[i].sd; out_recv_ready = vecs[i].rr;
      tick();
      chk($sformatf("vec%0d_done", i),  in_send_done,   vecs[i].dn);
      chk($sformatf("vec%0d_valid", i), out_recv_valid, vecs[i].vl);
      chk($sformatf("vec%0d_count", i), count,          vecs[i].cn);
      chk($sformatf("vec%0d_full", i),  full,           vecs[i].fl);
      if (vecs[i].vl) chk($sformatf("vec%0d_data", i), out_recv_data, vecs[i].dt);
    end

    // Eight words streamed with continuous popping: both pointers wrap twice.
    rst = 0; in_send_ready = 1; in_send_data = 32'h10; out_recv_ready = 1;
    n = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 100) begin
      if (out_recv_valid) begin
        chk("wrap_order", out_recv_data, 32'h10 + got);
        got++;
      end
      tick();
      cyc++;
      chk("wrap_count_le_depth", 32'(count <= 3'(DEPTH)), 1);
      if (in_send_done) begin
        n++;
        if (n < 8) in_send_data = 32'h10 + n;
        else       in_send_ready = 0;
      end
    end
    chk("wrap_words_seen", got, 8);
    chk("wrap_empty_after", out_recv_valid, 0);

    // Mid-stream reset with a word held on the send side.
    out_recv_ready = 0; in_send_ready = 1; in_send_data = 32'hB1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 50) begin
      tick();
      cyc++;
      if (in_send_done) begin
        n++;
        in_send_data = in_send_data + 1;
      end
    end
    chk("rst_pre_count", count, 3);
    rst = 1; in_send_data = 32'hA5;
    tick();
    chk("rst_count", count, 0);
    chk("rst_valid", out_recv_valid, 0);
    chk("rst_done", in_send_done, 0);
    rst = 0;
    tick();
    chk("rst_after_done", in_send_done, 1);
    chk("rst_after_count", count, 1);
    chk("rst_after_valid", out_recv_valid, 1);
    chk("rst_after_data", out_recv_data, 32'hA5);
    in_send_ready = 0; out_recv_ready = 1;
    tick();
    chk("rst_drain_count", count, 0);
    chk("rst_drain_done", in_send_done, 0);
    out_recv_ready = 0;

    // Random traffic against a queue model of the link.
    q.delete();
    done_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (in_send_ready && in_send_done) begin
        in_send_ready = ($urandom_range(0, 1) == 1);
        in_send_data  = $urandom;
      end else if (!in_send_ready) begin
        in_send_ready = ($urandom_range(0, 2) != 0);
        in_send_data  = $urandom;
      end
      out_recv_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);

      acc_m = in_send_ready && (q.size() < DEPTH) && !done_m && !rst;
      pop_m = (q.size() != 0) && out_recv_ready && !rst;
      tick();
      if (rst) begin
        q.delete();
        done_m = 1'b0;
      end else begin
        if (pop_m) void'(q.pop_front());
        if (acc_m) q.push_back(in_send_data);
        done_m = acc_m;
      end
      chk("rnd_count", count, q.size());
      chk("rnd_valid", out_recv_valid, 32'(q.size() != 0));
      chk("rnd_full",  full, 32'(q.size() == DEPTH));
      chk("rnd_done",  in_send_done, done_m);
      if (q.size() != 0) chk("rnd_data", out_recv_data, q[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
